// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and default width.
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// 1-bit full adder built from two half adders whose carries are ORed together.
module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    assign w_s1 = i_a ^ i_b;
    assign w_c1 = i_a & i_b;
    assign o_s  = w_s1 ^ i_c;
    assign w_c2 = w_s1 & i_c;
    assign o_co = w_c1 | w_c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: sequences one fa_cell LSB-first, one bit per clock.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [1:0]       dbg_state
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
    logic             w_s;
    logic             w_co;

    fa_cell u_fa (
        .i_a  (r_sa[0]),
        .i_b  (r_sb[0]),
        .i_c  (r_carry),
        .o_s  (w_s),
        .o_co (w_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_carry <= cin;
                        r_sum   <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Sum fills from the top so that after WIDTH shifts bit 0 sits at sum[0].
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_sum   <= (r_sum >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_cout  <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: an 8-bit and a 1-bit instance sharing clock and reset.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       ready8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;
    logic [1:0] st8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       ready1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;
    logic [1:0] st1;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .ready     (ready8),
        .busy      (busy8),
        .done      (done8),
        .sum       (sum8),
        .cout      (cout8),
        .dbg_state (st8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .ready     (ready1),
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .cout      (cout1),
        .dbg_state (st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one 8-bit operation; optionally re-pulses start with other operands mid-RUN.
    task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [7:0] es, input logic ec,
                        input int repulse_cyc);
        int busy_n;
        int done_n;
        int done_at;
        busy_n  = 0;
        done_n  = 0;
        done_at = 0;
        a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            if (cyc == repulse_cyc) begin
                a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            if (busy8) busy_n++;
            if (done8) begin
                done_n++;
                if (done_at == 0) done_at = cyc;
            end
            tick();
        end
        chk({tag, "_busy_cycles"}, busy_n, 8);
        chk({tag, "_done_cycle"}, done_at, 9);
        chk({tag, "_done_count"}, done_n, 1);
        chk({tag, "_sum"}, sum8, es);
        chk({tag, "_cout"}, cout8, ec);
        chk({tag, "_ready_after"}, ready8, 1);
    endtask

    initial begin
        int done_at;
        int done_n;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_ready", ready8, 1);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 8'h00);
        chk("rst_cout", cout8, 0);
        chk("rst_state", st8, 2'd0);

        run8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 0);
        repeat (3) tick();
        chk("hold_sum", sum8, 8'h96);
        chk("hold_done", done8, 0);

        run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        run8("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 0);
        run8("ignore_start", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 3);

        // Start held high: second operation begins right after the IDLE cycle.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        tick();
        chk("held_state_run", st8, 2'd1);
        repeat (8) tick();
        chk("held_done1", done8, 1);
        a8 = 8'h40; b8 = 8'h41; cin8 = 1'b1;
        tick();
        chk("held_idle", ready8, 1);
        tick();
        chk("held_rerun", busy8, 1);
        start8 = 1'b0;
        repeat (8) tick();
        chk("held_done2", done8, 1);
        chk("held_sum2", sum8, 8'h82);
        tick();

        // Reset during RUN cycle 4: three bits of 0xAA+0x55 already in sum (0xE0).
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_sum_partial", sum8, 8'hE0);
        rst = 1'b1;
        #1;
        chk("mid_rst_sum", sum8, 8'h00);
        chk("mid_rst_busy", busy8, 0);
        chk("mid_rst_ready", ready8, 1);
        chk("mid_rst_state", st8, 2'd0);
        tick();
        rst = 1'b0;
        done_n = 0;
        for (int i = 0; i < 10; i++) begin
            if (done8) done_n++;
            tick();
        end
        chk("mid_rst_no_done", done_n, 0);
        run8("add_aa_55_c", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 0);

        // WIDTH=1 instance: 1+1+1 = 0b11.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        done_at = 0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            if (cyc == 1) chk("w1_busy", busy1, 1);
            if (done1 && done_at == 0) done_at = cyc;
            tick();
        end
        chk("w1_done_cycle", done_at, 2);
        chk("w1_sum", sum1, 1);
        chk("w1_cout", cout1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
